serial_add_ctrl: RTL and testbench

Bit-serial adder sequencer that time-shares one 1-bit full-adder cell to add two WIDTH-bit operands, LSB first, one bit per clock. It owns the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake. The full adder itself stays external and connects through the FA_* ports. The block sits between a requesting master and a single FullAdder instance.

---
 rtl/serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_serial_add_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
// Time-shares one external 1-bit full adder to add two WIDTH-bit operands,
// LSB first, one bit per clock. Owns operand shifters, carry flop, bit
// counter and the START/DONE handshake.
//
//   state  | meaning
//   IDLE   | waiting for START; result outputs hold the last sum
//   RUN    | one operand bit pair fed to the full adder per clock
//   FIN    | DONE pulse; SUM/COUT_OUT valid and held afterwards
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic             CIN_INIT,
    output logic             FA_A,
    output logic             FA_B,
    output logic             FA_CIN,
    input  logic             FA_S,
    input  logic             FA_COUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT_OUT
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    // Only WIDTH-1 collected sum bits need storing: the final bit comes
    // straight from FA_S on the FIN entry edge when SUM is loaded.
    logic [WIDTH-2:0] r_sum_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_run;
    logic [WIDTH-1:0] w_sum_full;

    assign w_run      = (r_state == S_RUN);
    assign w_sum_full = {FA_S, r_sum_sh};

    // Full-adder drive is gated so the shared cell sees zeros outside RUN
    always_comb begin
        FA_A   = w_run & r_a_sh[0];
        FA_B   = w_run & r_b_sh[0];
        FA_CIN = w_run & r_carry;
    end

    assign BUSY     = w_run;
    assign DONE     = (r_state == S_FIN);
    assign SUM      = r_sum;
    assign COUT_OUT = r_cout;

    // Sequencer FSM plus datapath registers; reset aborts any operation
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_a_sh  <= OP_A;
                        r_b_sh  <= OP_B;
                        r_carry <= CIN_INIT;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum_sh <= (WIDTH-1)'(w_sum_full >> 1);
                    r_carry  <= FA_COUT;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    if (r_cnt == LAST_BIT) begin
                        // counter parks at the last bit rather than wrapping
                        r_sum   <= w_sum_full;
                        r_cout  <= FA_COUT;
                        r_state <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl with a behavioural full adder on FA_*.
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_add_ctrl;

    localparam int W = 8;
    localparam int MASK = (1 << W) - 1;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic [W-1:0] OP_A = '0;
    logic [W-1:0] OP_B = '0;
    logic         CIN_INIT = 1'b0;
    logic         FA_A, FA_B, FA_CIN, FA_S, FA_COUT;
    logic         BUSY, DONE, COUT_OUT;
    logic [W-1:0] SUM;

    int n_checks = 0;
    int n_errors = 0;
    int prev_sum = 0;
    int prev_cout = 0;
    int done_seen;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .OP_A(OP_A), .OP_B(OP_B), .CIN_INIT(CIN_INIT),
        .FA_A(FA_A), .FA_B(FA_B), .FA_CIN(FA_CIN),
        .FA_S(FA_S), .FA_COUT(FA_COUT),
        .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT_OUT(COUT_OUT)
    );

    // behavioural full adder cell
    assign FA_S    = FA_A ^ FA_B ^ FA_CIN;
    assign FA_COUT = (FA_A & FA_B) | (FA_CIN & (FA_A ^ FA_B));

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tick until DONE (bounded); done_seen reports how many ticks it took, -1 on timeout
    task automatic wait_done(input string tag);
        done_seen = -1;
        for (int n = 1; n <= 4 * W; n++) begin
            tick();
            if (DONE === 1'b1) begin
                done_seen = n;
                break;
            end
        end
        if (done_seen < 0) check({tag, "_timeout"}, 32'(DONE), 32'd1);
    endtask

    // One full operation; inject > 0 re-pulses START with other operands in that RUN cycle
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input int inject);
        int exp;
        int busy_cnt;
        int n;
        int mk;
        exp = int'(a) + int'(b) + int'(cin);
        OP_A = a; OP_B = b; CIN_INIT = cin; START = 1'b1;
        tick();
        START = 1'b0;
        check({tag, "_busy_first"}, 32'(BUSY), 32'd1);
        check({tag, "_sum_held"}, 32'(SUM), 32'(prev_sum));
        check({tag, "_cout_held"}, 32'(COUT_OUT), 32'(prev_cout));
        busy_cnt = 0;
        n = 0;
        done_seen = 0;
        while (done_seen == 0 && n < 4 * W) begin
            if (BUSY === 1'b1) begin
                mk = (1 << busy_cnt) - 1;
                check({tag, "_fa_a"}, 32'(FA_A), 32'((int'(a) >> busy_cnt) & 1));
                check({tag, "_fa_b"}, 32'(FA_B), 32'((int'(b) >> busy_cnt) & 1));
                check({tag, "_fa_cin"}, 32'(FA_CIN),
                      32'((((int'(a) & mk) + (int'(b) & mk) + int'(cin)) >> busy_cnt) & 1));
                busy_cnt++;
            end
            if (inject == busy_cnt) begin
                OP_A = 8'h11; OP_B = 8'h22; CIN_INIT = 1'b1; START = 1'b1;
            end
            tick();
            START = 1'b0;
            n++;
            if (DONE === 1'b1) done_seen = 1;
        end
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
        check({tag, "_sum"}, 32'(SUM), 32'(exp & MASK));
        check({tag, "_cout"}, 32'(COUT_OUT), 32'((exp >> W) & 1));
        check({tag, "_busy_at_done"}, 32'(BUSY), 32'd0);
        check({tag, "_fa_idle"}, 32'({FA_A, FA_B, FA_CIN}), 32'd0);
        prev_sum = exp & MASK;
        prev_cout = (exp >> W) & 1;
        tick();
        check({tag, "_done_once"}, 32'(DONE), 32'd0);
        check({tag, "_sum_hold"}, 32'(SUM), 32'(prev_sum));
    endtask

    initial begin
        int dcount;
        logic [W-1:0] ra, rb;
        logic rc;

        // reset
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_sum", 32'(SUM), 32'd0);
        check("rst_cout", 32'(COUT_OUT), 32'd0);
        check("rst_fa", 32'({FA_A, FA_B, FA_CIN}), 32'd0);

        // reset overrides START
        RST = 1'b1; START = 1'b1;
        tick();
        RST = 1'b0; START = 1'b0;
        check("rst_over_start", 32'(BUSY), 32'd0);

        do_op("basic", 8'h3C, 8'h5A, 1'b0, 0);
        do_op("ripple", 8'hFF, 8'h01, 1'b0, 0);
        do_op("max_cin", 8'hFF, 8'hFF, 1'b1, 0);
        do_op("zero", 8'h00, 8'h00, 1'b0, 0);
        do_op("ign_start", 8'h3C, 8'h5A, 1'b0, 3);

        // START held high through RUN and FIN: accepted only in the following IDLE cycle
        OP_A = 8'h0F; OP_B = 8'h01; CIN_INIT = 1'b0; START = 1'b1;
        tick();
        OP_A = 8'hAA; OP_B = 8'h55;
        check("hold_busy", 32'(BUSY), 32'd1);
        wait_done("hold");
        check("hold_latency", 32'(done_seen), 32'(W));
        check("hold_sum", 32'(SUM), 32'h10);
        tick();
        check("hold_idle_busy", 32'(BUSY), 32'd0);
        check("hold_idle_done", 32'(DONE), 32'd0);
        tick();
        START = 1'b0;
        check("hold_accept", 32'(BUSY), 32'd1);
        check("hold_sum_kept", 32'(SUM), 32'h10);
        wait_done("hold2");
        check("hold2_sum", 32'(SUM), 32'hFF);
        check("hold2_cout", 32'(COUT_OUT), 32'd0);
        prev_sum = 32'hFF;
        prev_cout = 0;
        tick();

        // reset in RUN cycle 4 aborts without a DONE pulse
        OP_A = 8'h3C; OP_B = 8'h5A; CIN_INIT = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        tick();
        check("abort_in_run", 32'(BUSY), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        check("abort_sum", 32'(SUM), 32'd0);
        check("abort_cout", 32'(COUT_OUT), 32'd0);
        prev_sum = 0;
        prev_cout = 0;
        dcount = 0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (DONE === 1'b1) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        do_op("after_abort", 8'h80, 8'h80, 1'b0, 0);

        // back-to-back: do_op ends in the IDLE cycle after DONE
        do_op("b2b_a", 8'h01, 8'h02, 1'b0, 0);
        do_op("b2b_b", 8'h7E, 8'h81, 1'b1, 0);

        // randomized operands
        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(1, 0));
            do_op("rand", ra, rb, rc, (i % 3 == 0) ? int'($urandom_range(W, 1)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
